// File: rtl/pwm_duty_decoder.sv
// PWM duty-cycle decoder: measures the high time of a fixed-period PWM input and
// recovers the 8-bit duty word, with frame-length checking, lock and timeout fault.
module pwm_duty_decoder #(
    parameter int PERIOD      = 1026,
    parameter int TOL         = 4,
    parameter int TIMEOUT     = 2048,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pwm_in,
    output logic [7:0] duty,
    output logic       valid,
    output logic       locked,
    output logic       fault
);

    localparam int              CW         = 12;
    localparam int              GW         = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0]   CNT_MAX    = '1;
    localparam logic [CW-1:0]   PERIOD_MIN = CW'(PERIOD - TOL);
    localparam logic [CW-1:0]   PERIOD_MAX = CW'(PERIOD + TOL);
    localparam logic [CW-1:0]   TIMEOUT_C  = CW'(TIMEOUT);
    localparam logic [GW-1:0]   LOCK_C     = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          sync_q;
    logic          s;
    logic          s_d;
    logic          rise;
    logic          fall;

    logic [CW-1:0] period_cnt;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] high_len;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_next;
    logic [CW-1:0] high_len_m1;
    logic [7:0]    duty_calc;

    logic          start;
    logic          close_high;
    logic          eval;
    logic          timeout;
    logic          frame_ok;
    logic          accept;
    logic          reject;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // Two-flop synchronizer for the asynchronous input, plus one history flop.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= pwm_in;
            s      <= sync_q;
            s_d    <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        close_high = 1'b0;
        eval       = 1'b0;
        timeout    = 1'b0;
        case (state)
            SEEK: begin
                if (rise) begin
                    start      = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (period_cnt >= TIMEOUT_C) begin
                    timeout    = 1'b1;
                    state_next = SEEK;
                end else if (fall) begin
                    close_high = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                // A rise on the timeout cycle still closes the frame; the length
                // check rejects it since TIMEOUT exceeds PERIOD+TOL.
                if (rise) begin
                    eval       = 1'b1;
                    start      = 1'b1;
                    state_next = HIGH;
                end else if (period_cnt >= TIMEOUT_C) begin
                    timeout    = 1'b1;
                    state_next = SEEK;
                end
            end
            default: begin
                state_next = SEEK;
            end
        endcase
    end

    assign frame_ok = (period_cnt >= PERIOD_MIN) && (period_cnt <= PERIOD_MAX);
    assign accept   = eval & frame_ok;
    assign reject   = eval & ~frame_ok;

    assign good_next   = (good_cnt >= LOCK_C) ? LOCK_C : good_cnt + GW'(1);
    assign high_len_m1 = high_len - CW'(1);

    always_comb begin
        duty_calc = 8'd0;
        if (high_len == '0) begin
            duty_calc = 8'd0;
        end else if (high_len_m1 > CW'(255)) begin
            duty_calc = 8'hff;
        end else begin
            duty_calc = high_len_m1[7:0];
        end
    end

    // Frame counters: both restart at 1 on the rise that opens a frame, so the
    // rise cycle itself is counted and synchronizer delay cancels out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            high_len   <= '0;
        end else begin
            if (start) begin
                period_cnt <= CW'(1);
                high_cnt   <= CW'(1);
            end else if (state == HIGH || state == LOW) begin
                period_cnt <= sat_inc(period_cnt);
                if (state == HIGH && s) begin
                    high_cnt <= sat_inc(high_cnt);
                end
            end
            if (close_high) begin
                high_len <= high_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            duty     <= 8'd0;
            valid    <= 1'b0;
            locked   <= 1'b0;
            fault    <= 1'b0;
            good_cnt <= '0;
        end else begin
            valid <= accept;
            if (accept) begin
                duty     <= duty_calc;
                fault    <= 1'b0;
                good_cnt <= good_next;
                locked   <= (good_next >= LOCK_C);
            end else if (reject || timeout) begin
                good_cnt <= '0;
                locked   <= 1'b0;
                if (timeout) begin
                    fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: clean frames, duty boundaries, tolerance
// limits, stuck input timeout, glitch recovery and mid-frame reset.
module tb_pwm_duty_decoder;

    localparam int TIMEOUT = 2048;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pwm_in;
    logic [7:0] duty;
    logic       valid;
    logic       locked;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    int   cyc            = 0;
    int   valid_pulses   = 0;
    int   valid_hi       = 0;
    int   last_valid_cyc = 0;
    int   snap           = 0;
    logic valid_prev     = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_decoder #(
        .PERIOD     (1026),
        .TOL        (4),
        .TIMEOUT    (TIMEOUT),
        .LOCK_FRAMES(2)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .pwm_in(pwm_in),
        .duty  (duty),
        .valid (valid),
        .locked(locked),
        .fault (fault)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the valid strobe away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            valid_hi       <= valid_hi + 1;
            last_valid_cyc <= cyc;
            if (!valid_prev) valid_pulses <= valid_pulses + 1;
        end
        valid_prev <= valid;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input int high, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            pwm_in = (i < high);
        end
    endtask

    task automatic glitch_frame();
        for (int i = 0; i < 1026; i++) begin
            @(negedge clk);
            pwm_in = (i < 20) || (i >= 21 && i < 51);
        end
    endtask

    // Valid pulses since the previous call, plus current output levels.
    task automatic expect_frame(input string tag, input int dp, input int d,
                                input logic lk, input logic ft);
        check({tag, ".valid"}, valid_pulses - snap, dp);
        snap = valid_pulses;
        check({tag, ".duty"}, duty, d);
        check({tag, ".locked"}, locked, lk);
        check({tag, ".fault"}, fault, ft);
    endtask

    task automatic wait_fault(input string tag, input int d);
        int n = 0;
        while (!fault && n < TIMEOUT + 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".fault"}, fault, 1);
        check({tag, ".latency"}, cyc - last_valid_cyc, TIMEOUT);
        check({tag, ".locked"}, locked, 0);
        check({tag, ".duty"}, duty, d);
    endtask

    initial begin
        resetn = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.duty", duty, 0);
        check("reset.valid", valid, 0);
        check("reset.locked", locked, 0);
        check("reset.fault", fault, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frames at duty 128.
        frame(129, 1026); expect_frame("clean1", 0, 0,   0, 0);
        frame(129, 1026); expect_frame("clean2", 1, 128, 0, 0);
        frame(129, 1026); expect_frame("clean3", 1, 128, 1, 0);
        frame(129, 1026); expect_frame("clean4", 1, 128, 1, 0);

        // Boundary high times; each result appears one boundary later.
        frame(1,   1026); expect_frame("bnd_a", 1, 128, 1, 0);
        frame(256, 1026); expect_frame("bnd_h1", 1, 0,   1, 0);
        frame(600, 1026); expect_frame("bnd_h256", 1, 255, 1, 0);
        frame(129, 1026); expect_frame("bnd_h600", 1, 255, 1, 0);

        // Frame length tolerance.
        frame(129, 1022); expect_frame("tol_pre", 1, 128, 1, 0);
        frame(65,  1030); expect_frame("tol_1022", 1, 128, 1, 0);
        frame(201, 1031); expect_frame("tol_1030", 1, 64, 1, 0);
        frame(201, 1021); expect_frame("tol_1031", 0, 64, 0, 0);
        frame(129, 1026); expect_frame("tol_1021", 0, 64, 0, 0);
        frame(129, 1026); expect_frame("tol_rec1", 1, 128, 0, 0);
        frame(129, 1026); expect_frame("tol_rec2", 1, 128, 1, 0);

        // Stuck low after lock.
        wait_fault("stuck_low", 128);
        expect_frame("stuck_low_st", 0, 128, 0, 1);
        frame(129, 1026); expect_frame("resume_l1", 0, 128, 0, 1);
        frame(129, 1026); expect_frame("resume_l2", 1, 128, 0, 0);
        frame(129, 1026); expect_frame("resume_l3", 1, 128, 1, 0);

        // Stuck high after lock.
        @(negedge clk);
        pwm_in = 1'b1;
        wait_fault("stuck_high", 128);
        expect_frame("stuck_high_st", 1, 128, 0, 1);
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        frame(51, 1026); expect_frame("resume_h1", 0, 128, 0, 1);
        frame(51, 1026); expect_frame("resume_h2", 1, 50, 0, 0);
        frame(51, 1026); expect_frame("resume_h3", 1, 50, 1, 0);

        // One-clock low glitch inside the high phase.
        glitch_frame();   expect_frame("glitch", 1, 50, 0, 0);
        frame(51, 1026);  expect_frame("glitch_k1", 0, 50, 0, 0);
        frame(51, 1026);  expect_frame("glitch_k2", 1, 50, 0, 0);
        frame(51, 1026);  expect_frame("glitch_k3", 1, 50, 1, 0);

        // Reset asserted mid high phase.
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        expect_frame("rst_pre", 1, 50, 1, 0);
        #2 resetn = 1'b0;
        #1;
        check("rst_async.duty", duty, 0);
        check("rst_async.valid", valid, 0);
        check("rst_async.locked", locked, 0);
        check("rst_async.fault", fault, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        pwm_in = 1'b0;
        repeat (500) @(negedge clk);
        snap = valid_pulses;
        frame(51, 1026); expect_frame("rst_p1", 0, 0,  0, 0);
        frame(51, 1026); expect_frame("rst_p2", 1, 50, 0, 0);

        repeat (5) @(negedge clk);
        check("valid_one_cycle", valid_hi, valid_pulses);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Single-channel PWM duty-cycle decoder for the microstepper current path. It measures the high time of an incoming fixed-period PWM waveform and recovers the 8-bit duty word that produced it. It inverts the `analog_out` PWM encoding: a duty of p gives a high time of p+1 clocks in a 1026-clock frame. It is used for loopback checking of the current-reference outputs and for accepting an external PWM current command. Frame-period checking, lock and timeout reporting let the stepper core reject bad input.

## Interface
- `PERIOD`, 1026: nominal frame length in clocks, measured rising edge to rising edge.
- `TOL`, 4: allowed deviation of the measured frame length from `PERIOD`, in clocks.
- `TIMEOUT`, 2048: clocks without a rising edge before `fault` is raised. Must satisfy TIMEOUT > PERIOD+TOL and TIMEOUT < 4096.
- `LOCK_FRAMES`, 2: number of consecutive accepted frames before `locked` asserts.

Ports:
- `clk`, input, 1: system clock. This is the one clock.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `pwm_in`, input, 1: PWM input, asynchronous to `clk`.
- `duty`, output, 8: last accepted duty value.
- `valid`, output, 1: one-cycle strobe, high when `duty` has just been updated.
- `locked`, output, 1: `LOCK_FRAMES` or more consecutive frames accepted.
- `fault`, output, 1: no rising edge seen within `TIMEOUT` clocks.

## Operation
- **Input conditioning**
  - `pwm_in` passes through a 2-flop synchronizer giving `s`, plus one history flop `s_d`.
  - rise = s & ~s_d; fall = ~s & s_d.
- **Counters**
  - `period_cnt` and `high_cnt` are 12 bits each and saturate at 4095.
  - `high_len` is 12 bits.
  - `good_cnt` saturates at `LOCK_FRAMES`.
- **FSM states:** SEEK, HIGH, LOW.
- **SEEK**
  - Wait for rise.
  - On rise: period_cnt=1, high_cnt=1, go to HIGH.
  - Only the timeout case enters SEEK, so `fault` is already set here. Stay in SEEK until a rise.
- **HIGH**
  - Each cycle: period_cnt++. If `s` is high, also high_cnt++.
  - On fall: high_len=high_cnt (no increment on that cycle), go to LOW.
- **LOW**
  - Each cycle: period_cnt++.
  - On rise, evaluate the frame using L = period_cnt (its value before restart):
    - Accept if |L−PERIOD| ≤ TOL.
      - duty = min(high_len−1, 255).
      - valid=1 for one cycle.
      - fault=0.
      - good_cnt++.
      - locked=1 once good_cnt reaches LOCK_FRAMES.
    - Reject otherwise: no valid, duty held, good_cnt=0, locked=0.
    - In both cases: restart with period_cnt=1, high_cnt=1, go to HIGH.
- **Timeout**
  - Applies in HIGH or LOW, when period_cnt reaches TIMEOUT with no rise on the same cycle.
  - Actions: fault=1, locked=0, good_cnt=0, duty held, go to SEEK.
- **Simultaneous rise and timeout:** the rise wins and the frame is evaluated. It is always rejected, because TIMEOUT > PERIOD+TOL.
- **First frame after reset or SEEK:** only its end is evaluated, so a partial frame at the start is rejected by the length check.
- **Glitches:** a low glitch inside a high phase creates a short frame. That frame is rejected and lock is dropped. The frame after it is usually rejected too.

## Timing
- **Reset values:** duty=0, valid=0, locked=0, fault=0. State=SEEK, synchronizer and history flops 0, all counters 0.
- Reset takes effect asynchronously on assertion. Release is sampled on the `clk` edge.
- **Latency:** a rise on `pwm_in` sampled at clock edge N is detected combinationally after edge N+1. `duty`/`valid`/`locked` update at edge N+2.
- `valid` is high for exactly one cycle per accepted frame.
- **Measurement accuracy:** high time and frame length are exact clock counts of the synchronized signal. Synchronizer delay cancels in both.
- **Reset mid-frame:** all outputs return to reset values immediately. Nothing is retained.
- **Input high at reset release:** seen as a rise, because the flops reset to 0. It starts a partial frame that is rejected as described above.

## Test plan
- **Clean frames, encoder duty 128:** 129 clocks high / 897 low, 4 frames.
  - valid pulses at frame boundaries 2, 3, 4, each with duty=128.
  - locked=1 after the second accepted frame.
  - fault stays 0.
- **Boundary high times:**
  - 1 clock high → duty=0.
  - 256 clocks → 255.
  - 600 clocks → 255 (saturated).
  - Period 1026 in all cases, all frames accepted.
- **Tolerance limits:**
  - Frame lengths 1022 and 1030 are accepted with valid.
  - 1031 and 1021 are rejected: no valid, locked drops to 0, duty unchanged.
- **Stuck input:** after lock, hold `pwm_in` low.
  - fault=1 and locked=0 exactly TIMEOUT clocks after the last detected rise; duty held.
  - Repeat holding `pwm_in` high; same response.
  - Resume clean frames: fault clears on the first accepted frame.
- **Glitch:** while locked at duty 50, insert a 1-clock low pulse inside the high phase.
  - The following boundaries are rejected and locked=0.
  - Clean frames then restore duty=50, and locked=1 after 2 accepted frames.
- **Reset mid-frame:** assert `resetn` low for 3 cycles during a high phase.
  - duty/valid/locked/fault read 0 before the next clock edge.
  - After release, the first accepted valid comes at the second clean frame boundary.
